input_tile_pingpong_buffer: RTL and testbench

//  Parametrised, double-banked successor of the single-bank input activation buffer.
//  - Loads an INPUT_HEIGHT x INPUT_WIDTH tile of BIN_LEN-bit activations from input SRAM,

---
 rtl/input_tile_pingpong_buffer_if.sv | 32 +++
 rtl/input_tile_pingpong_buffer.sv | 133 +++++++++++++
 tb/tb_input_tile_pingpong_buffer.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/input_tile_pingpong_buffer_if.sv
// Handshake bundle between the input SRAM loader, the tile buffer and the PE array.
// The row field has one spare code so that rows past the tile height can be expressed and flagged.
interface input_tile_pingpong_buffer_if #(
    parameter int BIN_LEN      = 8,
    parameter int INPUT_HEIGHT = 8,
    parameter int INPUT_WIDTH  = 8,
    parameter int SRAM_LEN     = 4
);
    localparam int ROW_W = $clog2(INPUT_HEIGHT + 1);
    localparam int COL_W = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;

    logic                                        wr_valid;
    logic                                        wr_ready;
    logic [ROW_W-1:0]                            wr_row;
    logic [COL_W-1:0]                            wr_col;
    logic [BIN_LEN*SRAM_LEN-1:0]                 wr_data;
    logic                                        wr_last;
    logic                                        rd_valid;
    logic                                        rd_release;
    logic [BIN_LEN*INPUT_HEIGHT*INPUT_WIDTH-1:0] r_val;
    logic                                        wr_err;

    modport master (
        output wr_valid, wr_row, wr_col, wr_data, wr_last, rd_release,
        input  wr_ready, rd_valid, r_val, wr_err
    );

    modport slave (
        input  wr_valid, wr_row, wr_col, wr_data, wr_last, rd_release,
        output wr_ready, rd_valid, r_val, wr_err
    );
endinterface

// File: rtl/input_tile_pingpong_buffer.sv
// Double-banked activation tile buffer: one bank fills from input SRAM while the other
// presents a complete zero-padded tile to the PE array.
module input_tile_pingpong_buffer #(
    parameter int BIN_LEN      = 8,
    parameter int INPUT_HEIGHT = 8,
    parameter int INPUT_WIDTH  = 8,
    parameter int SRAM_LEN     = 4
) (
    input logic                         clock,
    input logic                         reset,
    input_tile_pingpong_buffer_if.slave bus
);
    localparam int ROW_W     = $clog2(INPUT_HEIGHT + 1);
    localparam int COL_W     = (INPUT_WIDTH > 1) ? $clog2(INPUT_WIDTH) : 1;
    localparam int CSUM_W    = COL_W + 1;
    localparam int TILE_BITS = BIN_LEN * INPUT_HEIGHT * INPUT_WIDTH;

    typedef enum logic [1:0] {
        BANK_EMPTY,
        BANK_FILLING,
        BANK_FULL
    } bank_state_t;

    bank_state_t          state_q [2];
    bank_state_t          state_d [2];
    logic                 wr_bank_q, wr_bank_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 rd_valid_q, rd_valid_d;
    logic                 wr_err_q, wr_err_d;
    logic [TILE_BITS-1:0] tile_q [2];
    logic [TILE_BITS-1:0] tile_d [2];
    logic [CSUM_W-1:0]    col_sum [SRAM_LEN];

    logic wr_ready;
    logic wr_fire;
    logic rel_fire;
    logic row_ok;

    assign wr_ready = (state_q[wr_bank_q] != BANK_FULL);
    assign wr_fire  = bus.wr_valid && wr_ready;
    assign rel_fire = bus.rd_release && rd_valid_q;
    assign row_ok   = (bus.wr_row < ROW_W'(INPUT_HEIGHT));

    // One extra bit keeps wr_col+k from wrapping back into range.
    always_comb begin
        for (int k = 0; k < SRAM_LEN; k++) begin
            col_sum[k] = {1'b0, bus.wr_col} + CSUM_W'(k);
        end
    end

    // Bank status, bank pointers and the sticky error flag.
    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_err_d  = wr_err_q;

        // A released bank is FULL and a writable bank is not, so these never touch the same bank.
        if (rel_fire) begin
            state_d[rd_bank_q] = BANK_EMPTY;
            rd_bank_d          = ~rd_bank_q;
        end

        if (wr_fire) begin
            if (bus.wr_last) begin
                state_d[wr_bank_q] = BANK_FULL;
                wr_bank_d          = ~wr_bank_q;
            end else if (state_q[wr_bank_q] == BANK_EMPTY) begin
                state_d[wr_bank_q] = BANK_FILLING;
            end
            if (!row_ok) begin
                wr_err_d = 1'b1;
            end
        end

        rd_valid_d = (state_d[rd_bank_d] == BANK_FULL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q[0] <= BANK_EMPTY;
            state_q[1] <= BANK_EMPTY;
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            // NOTE: all clocked state uses non-blocking assignment so every register samples pre-edge values.
            state_q    <= state_d;
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            rd_valid_q <= rd_valid_d;
            wr_err_q   <= wr_err_d;
        end
    end

    // Bank contents are stored in r_val order, so presenting a tile is a plain mux.
    always_comb begin
        // NOTE: combinational next-value logic starts from a full default, so partial updates never infer latches.
        tile_d[0] = tile_q[0];
        tile_d[1] = tile_q[1];

        if (rel_fire) begin
            tile_d[rd_bank_q] = '0;
        end

        if (wr_fire && row_ok) begin
            for (int k = 0; k < SRAM_LEN; k++) begin
                if (col_sum[k] < CSUM_W'(INPUT_WIDTH)) begin
                    tile_d[wr_bank_q][(int'(bus.wr_row) * INPUT_WIDTH + int'(col_sum[k])) * BIN_LEN +: BIN_LEN] =
                        bus.wr_data[k*BIN_LEN +: BIN_LEN];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the banks are flops, not SRAM, and must be zero-filled on reset because unwritten pixels read 0.
            tile_q[0] <= '0;
            tile_q[1] <= '0;
        end else begin
            tile_q[0] <= tile_d[0];
            tile_q[1] <= tile_d[1];
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_err   = wr_err_q;
    assign bus.r_val    = rd_valid_q ? tile_q[rd_bank_q] : '0;

endmodule

// File: tb/tb_input_tile_pingpong_buffer.sv
// Scoreboard bench for the ping-pong tile buffer: the driver keeps a pixel-array model of the
// tile being filled and queues each closed tile; a negedge monitor compares what the DUT presents.
module tb_input_tile_pingpong_buffer;
    localparam int BIN_LEN      = 8;
    localparam int INPUT_HEIGHT = 8;
    localparam int INPUT_WIDTH  = 8;
    localparam int SRAM_LEN     = 4;
    localparam int TILE_BITS    = BIN_LEN * INPUT_HEIGHT * INPUT_WIDTH;
    localparam int BEAT_BITS    = BIN_LEN * SRAM_LEN;
    localparam int ROW_W        = $clog2(INPUT_HEIGHT + 1);
    localparam int COL_W        = $clog2(INPUT_WIDTH);

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    input_tile_pingpong_buffer_if #(
        .BIN_LEN(BIN_LEN), .INPUT_HEIGHT(INPUT_HEIGHT),
        .INPUT_WIDTH(INPUT_WIDTH), .SRAM_LEN(SRAM_LEN)
    ) bus ();

    input_tile_pingpong_buffer #(
        .BIN_LEN(BIN_LEN), .INPUT_HEIGHT(INPUT_HEIGHT),
        .INPUT_WIDTH(INPUT_WIDTH), .SRAM_LEN(SRAM_LEN)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int pass_cnt  = 0;
    int check_cnt = 0;

    // Reference model: the tile being filled, closed tiles awaiting release, and the error flag.
    logic [TILE_BITS-1:0] fill_tile = '0;
    logic [TILE_BITS-1:0] exp_q[$];
    int                   full_cnt  = 0;
    bit                   exp_err   = 1'b0;
    bit                   mon_en    = 1'b0;

    task automatic check(input string name, input logic [TILE_BITS-1:0] act,
                         input logic [TILE_BITS-1:0] exp);
        check_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // One clock of stimulus; the model decides acceptance from tile capacity (two banks).
    task automatic drive_cycle(input bit wv, input int row, input int col,
                               input logic [BEAT_BITS-1:0] data, input bit last, input bit rel);
        bit acc;
        bit relf;
        bus.wr_valid   = wv;
        bus.wr_row     = ROW_W'(row);
        bus.wr_col     = COL_W'(col);
        bus.wr_data    = data;
        bus.wr_last    = last;
        bus.rd_release = rel;
        @(negedge clock);
        acc  = wv && (full_cnt < 2);
        relf = rel && (full_cnt > 0);
        @(posedge clock);
        #1;
        if (relf) full_cnt--;
        if (acc) begin
            if (row < INPUT_HEIGHT) begin
                for (int k = 0; k < SRAM_LEN; k++)
                    if (col + k < INPUT_WIDTH)
                        fill_tile[(row*INPUT_WIDTH + col + k)*BIN_LEN +: BIN_LEN] = data[k*BIN_LEN +: BIN_LEN];
            end else begin
                exp_err = 1'b1;
            end
            if (last) begin
                exp_q.push_back(fill_tile);
                fill_tile = '0;
                full_cnt++;
            end
        end
        bus.wr_valid   = 1'b0;
        bus.wr_last    = 1'b0;
        bus.rd_release = 1'b0;
    endtask

    task automatic write_beat(input int row, input int col, input logic [BEAT_BITS-1:0] data, input bit last);
        drive_cycle(1'b1, row, col, data, last, 1'b0);
    endtask

    task automatic release_tile();
        drive_cycle(1'b0, 0, 0, '0, 1'b0, 1'b1);
    endtask

    task automatic idle();
        drive_cycle(1'b0, 0, 0, '0, 1'b0, 1'b0);
    endtask

    task automatic rand_tile(input int beats);
        for (int b = 0; b < beats; b++)
            write_beat($urandom_range(0, INPUT_HEIGHT-1), $urandom_range(0, INPUT_WIDTH-1),
                       $urandom, b == beats - 1);
    endtask

    // Rows written in two beats at columns 0 and 4; element k carries r*8+col+k.
    task automatic load_ramp();
        logic [BEAT_BITS-1:0] d;
        for (int r = 0; r < INPUT_HEIGHT; r++) begin
            for (int c = 0; c < INPUT_WIDTH; c += SRAM_LEN) begin
                for (int k = 0; k < SRAM_LEN; k++) d[k*BIN_LEN +: BIN_LEN] = BIN_LEN'(r*8 + c + k);
                write_beat(r, c, d, (r == INPUT_HEIGHT-1) && (c + SRAM_LEN >= INPUT_WIDTH));
            end
        end
    endtask

    task automatic check_ramp();
        logic [TILE_BITS-1:0] ramp;
        for (int i = 0; i < INPUT_HEIGHT; i++)
            for (int j = 0; j < INPUT_WIDTH; j++)
                ramp[(i*INPUT_WIDTH + j)*BIN_LEN +: BIN_LEN] = BIN_LEN'(i*8 + j);
        check("ramp_tile", bus.r_val, ramp);
    endtask

    task automatic do_reset(input int n);
        mon_en         = 1'b0;
        reset          = 1'b1;
        bus.wr_valid   = 1'b0;
        bus.wr_last    = 1'b0;
        bus.rd_release = 1'b0;
        repeat (n) @(posedge clock);
        #1;
        reset     = 1'b0;
        fill_tile = '0;
        exp_q.delete();
        full_cnt  = 0;
        exp_err   = 1'b0;
        mon_en    = 1'b1;
    endtask

    // Monitor: flag/handshake outputs every cycle; the presented tile against the queue head.
    always @(negedge clock) begin
        if (mon_en) begin
            check("rd_valid", TILE_BITS'(bus.rd_valid), TILE_BITS'(full_cnt > 0));
            check("wr_ready", TILE_BITS'(bus.wr_ready), TILE_BITS'(full_cnt < 2));
            check("wr_err",   TILE_BITS'(bus.wr_err),   TILE_BITS'(exp_err));
            if (bus.rd_valid) begin
                if (exp_q.size() == 0) begin
                    check_cnt++;
                    $display("FAIL tile_presented: rd_valid=1 but no closed tile expected at %0t", $time);
                end else begin
                    check("r_val", bus.r_val, exp_q[0]);
                    if (bus.rd_release) void'(exp_q.pop_front());
                end
            end else begin
                check("r_val_zero", bus.r_val, '0);
            end
        end
    end

    initial begin
        bus.wr_valid   = 1'b0;
        bus.wr_row     = '0;
        bus.wr_col     = '0;
        bus.wr_data    = '0;
        bus.wr_last    = 1'b0;
        bus.rd_release = 1'b0;
        do_reset(2);
        idle();

        // Full ramp tile, presented one cycle after the last beat.
        load_ramp();
        check_ramp();
        idle();
        release_tile();
        idle();

        // Single beat hanging off the right edge.
        write_beat(2, 6, 32'h0403_0201, 1'b1);
        idle();
        release_tile();

        // Out-of-range row: dropped, closes the tile, sets the sticky error.
        write_beat(1, 0, $urandom, 1'b0);
        write_beat(9, 0, $urandom, 1'b1);
        idle();
        release_tile();
        idle();

        // Both banks full: extra beats are held off until a release.
        rand_tile(5);
        rand_tile(3);
        repeat (3) write_beat(4, 4, $urandom, 1'b0);
        release_tile();
        idle();
        release_tile();
        idle();

        // Release and wr_last in the same cycle, then refill the released bank with one beat.
        rand_tile(4);
        write_beat(3, 2, $urandom, 1'b0);
        drive_cycle(1'b1, 5, 0, $urandom, 1'b1, 1'b1);
        idle();
        write_beat(0, 0, $urandom, 1'b1);
        release_tile();
        release_tile();
        idle();

        // Reset with one bank full and the other filling, then a fresh ramp load.
        rand_tile(4);
        write_beat(6, 1, $urandom, 1'b0);
        write_beat(7, 3, $urandom, 1'b0);
        do_reset(1);
        idle();
        load_ramp();
        check_ramp();
        release_tile();
        idle();

        // Randomised traffic including illegal rows, edge columns and overlapping releases.
        for (int n = 0; n < 400; n++)
            drive_cycle(($urandom % 4) != 0, $urandom_range(0, 9), $urandom_range(0, INPUT_WIDTH-1),
                        $urandom, ($urandom % 6) == 0, ($urandom % 3) == 0);
        repeat (3) release_tile();
        idle();

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
